// File: rtl/seg_pkg.sv
// Shared seven-segment definitions for the scoreboard display path.
// Segment codes are active-low with bit 6 = segment a ... bit 0 = segment g.
// Anode codes are active-low one-hot selects for the four digit slots.
package seg_pkg;

   localparam logic [6:0] SEG_0     = 7'b0000001;
   localparam logic [6:0] SEG_1     = 7'b1001111;
   localparam logic [6:0] SEG_2     = 7'b0010010;
   localparam logic [6:0] SEG_3     = 7'b0000110;
   localparam logic [6:0] SEG_4     = 7'b1001100;
   localparam logic [6:0] SEG_5     = 7'b0100100;
   localparam logic [6:0] SEG_6     = 7'b0100000;
   localparam logic [6:0] SEG_7     = 7'b0001111;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0000100;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   localparam logic [3:0] AN_ONES  = 4'b1110;
   localparam logic [3:0] AN_TENS  = 4'b1101;
   localparam logic [3:0] AN_HUNDS = 4'b1011;
   localparam logic [3:0] AN_THOUS = 4'b0111;

   typedef enum logic [1:0] {
      COLLECT = 2'd0,
      CONV    = 2'd1,
      DONE    = 2'd2
   } state_t;

endpackage

// File: rtl/seg_scan_to_bin_if.sv
// Display scan bus plus the reconstructed-value outputs.
//   led   : segment bus, active-low (display driver -> reader)
//   a     : anode strobes, active-low (display driver -> reader)
//   num   : last converted value
//   valid : one-cycle pulse when num updates
//   err   : one-cycle pulse when a frame is discarded
//   busy  : conversion in progress
interface seg_scan_to_bin_if;
   logic [6:0]  led;
   logic [3:0]  a;
   logic [13:0] num;
   logic        valid;
   logic        err;
   logic        busy;

   modport master (output led, a, input num, valid, err, busy);
   modport slave  (input led, a, output num, valid, err, busy);
endinterface

// File: rtl/seg_to_dec.sv
// Inverse of the display digit decoder: active-low segment code to BCD digit.
//   i_seg : segment code, bit 6 = a
//   o_dig : decoded digit (0 when not a digit)
//   o_ok  : code is one of the ten digit patterns
module seg_to_dec
   import seg_pkg::*;
(
   input  logic [6:0] i_seg,
   output logic [3:0] o_dig,
   output logic       o_ok
);

   always_comb begin
      o_dig = 4'd0;
      o_ok  = 1'b1;
      case (i_seg)
         SEG_0:     o_dig = 4'd0;
         SEG_1:     o_dig = 4'd1;
         SEG_2:     o_dig = 4'd2;
         SEG_3:     o_dig = 4'd3;
         SEG_4:     o_dig = 4'd4;
         SEG_5:     o_dig = 4'd5;
         SEG_6:     o_dig = 4'd6;
         SEG_7:     o_dig = 4'd7;
         SEG_8:     o_dig = 4'd8;
         SEG_9:     o_dig = 4'd9;
         SEG_BLANK: o_ok  = 1'b0;
         default:   o_ok  = 1'b0;
      endcase
   end

endmodule

// File: rtl/seg_scan_to_bin.sv
// Reads back a multiplexed 4-digit seven-segment scan and reconstructs the
// displayed number in binary via a sequential reverse double-dabble.
//   clk : system clock, rising edge
//   rst : synchronous active-high reset
//   bus : slave side of seg_scan_to_bin_if (led/a in; num/valid/err/busy out)
//
// state   | meaning
// --------+------------------------------------------------------------
// COLLECT | capture stable digits into slots until all four are seen
// CONV    | 14 shift/correct iterations on {bcd16, bin14}
// DONE    | result loaded into num, valid pulsing; back to COLLECT
module seg_scan_to_bin
   import seg_pkg::*;
#(
   parameter int STABLE_CYCLES = 4
) (
   input  logic           clk,
   input  logic           rst,
   seg_scan_to_bin_if.slave bus
);

   localparam int             CW      = $clog2(STABLE_CYCLES + 1);
   localparam logic [CW-1:0] CAP_CNT = CW'(STABLE_CYCLES - 1);
   // Saturating one past the capture count keeps a long dwell from re-capturing.
   localparam logic [CW-1:0] SAT_CNT = CW'(STABLE_CYCLES);

   state_t            r_state, w_state_nxt;
   logic [10:0]       r_prev;
   logic [CW-1:0]     r_dwell, w_cnt;
   logic [3:0]        r_seen, w_seen_nxt;
   logic [3:0][3:0]   r_dig, w_dig_nxt;
   logic [29:0]       r_conv, w_shift, w_step;
   logic [3:0]        r_iter;
   logic [13:0]       r_num;
   logic              r_valid, r_err;
   logic [10:0]       w_pat;
   logic [1:0]        w_slot;
   logic              w_slot_ok, w_dec_ok, w_tick, w_cap_ok, w_cap_bad, w_frame, w_last;
   logic [3:0]        w_dec;

   seg_to_dec u_dec (.i_seg(bus.led), .o_dig(w_dec), .o_ok(w_dec_ok));

   assign w_pat = {bus.a, bus.led};

   always_comb begin
      if (w_pat != r_prev)         w_cnt = '0;
      else if (r_dwell == SAT_CNT) w_cnt = SAT_CNT;
      else                         w_cnt = r_dwell + CW'(1);
   end

   always_comb begin
      w_slot    = 2'd0;
      w_slot_ok = 1'b1;
      case (bus.a)
         AN_ONES:  w_slot = 2'd0;
         AN_TENS:  w_slot = 2'd1;
         AN_HUNDS: w_slot = 2'd2;
         AN_THOUS: w_slot = 2'd3;
         default:  w_slot_ok = 1'b0;
      endcase
   end

   assign w_tick     = (w_cnt == CAP_CNT) && w_slot_ok && (r_state == COLLECT);
   assign w_cap_ok   = w_tick && w_dec_ok;
   assign w_cap_bad  = w_tick && !w_dec_ok;
   assign w_seen_nxt = r_seen | (4'b0001 << w_slot);
   assign w_frame    = w_cap_ok && (w_seen_nxt == 4'b1111);

   always_comb begin
      w_dig_nxt = r_dig;
      if (w_cap_ok) w_dig_nxt[w_slot] = w_dec;
   end

   // One reverse double-dabble iteration: shift right, then pull each BCD
   // nibble that landed at 8 or above back down by 3.
   always_comb begin
      w_shift = r_conv >> 1;
      w_step  = w_shift;
      for (int k = 0; k < 4; k++) begin
         if (w_shift[14 + 4*k +: 4] >= 4'd8)
            w_step[14 + 4*k +: 4] = w_shift[14 + 4*k +: 4] - 4'd3;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_last      = 1'b0;
      case (r_state)
         COLLECT: if (w_frame) w_state_nxt = CONV;
         CONV: begin
            if (r_iter == 4'd13) begin
               w_last      = 1'b1;
               w_state_nxt = DONE;
            end
         end
         DONE:    w_state_nxt = COLLECT;
         default: w_state_nxt = COLLECT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) r_state <= COLLECT;
      else     r_state <= w_state_nxt;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_prev  <= '0;
         r_dwell <= '0;
         r_seen  <= '0;
         r_dig   <= '0;
         r_conv  <= '0;
         r_iter  <= '0;
         r_num   <= '0;
         r_valid <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_prev  <= w_pat;
         r_dwell <= w_cnt;
         r_valid <= w_last;
         r_err   <= w_cap_bad;
         if (w_cap_bad) begin
            r_seen <= '0;
            r_dig  <= '0;
         end else if (w_frame) begin
            r_seen <= '0;
            r_dig  <= w_dig_nxt;
            r_conv <= {w_dig_nxt, 14'd0};
            r_iter <= '0;
         end else if (w_cap_ok) begin
            r_seen <= w_seen_nxt;
            r_dig  <= w_dig_nxt;
         end
         if (r_state == CONV) begin
            r_conv <= w_step;
            r_iter <= r_iter + 4'd1;
         end
         if (w_last) r_num <= w_step[13:0];
      end
   end

   assign bus.num   = r_num;
   assign bus.valid = r_valid;
   assign bus.err   = r_err;
   assign bus.busy  = (r_state == CONV);

endmodule

// File: tb/tb_seg_scan_to_bin.sv
module tb_seg_scan_to_bin;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   seg_scan_to_bin_if bus ();
   seg_scan_to_bin #(.STABLE_CYCLES(4)) dut (.clk(clk), .rst(rst), .bus(bus));

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;
   int valid_cnt = 0, err_cnt = 0, busy_cnt = 0, both_cnt = 0;
   int valid_cyc = 0, err_cyc = 0;
   int last_n = 0;
   logic [13:0] last_num = '0;

   typedef struct {
      int          value;
      int          dwell;
      int          rot;
      logic [13:0] exp_num;
   } vec_t;
   vec_t tbl[6];

   // Event monitor, sampled 1 time unit after each rising edge.
   always @(posedge clk) begin
      cyc++;
      #1;
      if (bus.valid) begin
         valid_cnt++;
         valid_cyc = cyc;
         last_num  = bus.num;
      end
      if (bus.err) begin
         err_cnt++;
         err_cyc = cyc;
      end
      if (bus.busy) busy_cnt++;
      if (bus.valid && bus.err) both_cnt++;
   end

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic logic [6:0] seg_of(input int d);
      case (d)
         0: return 7'b0000001;
         1: return 7'b1001111;
         2: return 7'b0010010;
         3: return 7'b0000110;
         4: return 7'b1001100;
         5: return 7'b0100100;
         6: return 7'b0100000;
         7: return 7'b0001111;
         8: return 7'b0000000;
         9: return 7'b0000100;
         default: return 7'b1111111;
      endcase
   endfunction

   function automatic logic [3:0] an_of(input int s);
      case (s)
         0: return 4'b1110;
         1: return 4'b1101;
         2: return 4'b1011;
         default: return 4'b0111;
      endcase
   endfunction

   function automatic int dig_of(input int v, input int s);
      case (s)
         0: return v % 10;
         1: return (v / 10) % 10;
         2: return (v / 100) % 10;
         default: return (v / 1000) % 10;
      endcase
   endfunction

   // Blank for one cycle (breaks any dwell), then hold a pattern for dwell cycles.
   task automatic show(input logic [3:0] an, input logic [6:0] seg, input int dwell);
      bus.a   = 4'hF;
      bus.led = 7'h7F;
      @(negedge clk);
      bus.a   = an;
      bus.led = seg;
      last_n  = cyc;
      repeat (dwell) @(negedge clk);
   endtask

   task automatic send_frame(input int v, input int dwell, input int rot);
      for (int k = 0; k < 4; k++) begin
         int s;
         s = (k + rot) % 4;
         show(an_of(s), seg_of(dig_of(v, s)), dwell);
      end
   endtask

   task automatic wait_valid(input int prev, input string name, input int exp);
      int t;
      t = 0;
      while (valid_cnt == prev && t < 60) begin
         @(negedge clk);
         t++;
      end
      check({name, " valid_count"}, valid_cnt, prev + 1);
      check({name, " num"}, int'(last_num), exp);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1);
   end

   initial begin
      int v0, b0, e0, v, d[4];
      bus.a   = 4'hF;
      bus.led = 7'h7F;

      tbl[0] = '{9999, 4, 0, 14'd9999};
      tbl[1] = '{0,    5, 1, 14'd0};
      tbl[2] = '{42,   6, 2, 14'd42};
      tbl[3] = '{1000, 4, 3, 14'd1000};
      tbl[4] = '{7,    9, 0, 14'd7};
      tbl[5] = '{8086, 4, 1, 14'd8086};

      rst = 1'b1;
      repeat (3) @(negedge clk);
      check("reset num",   int'(bus.num),   0);
      check("reset valid", int'(bus.valid), 0);
      check("reset err",   int'(bus.err),   0);
      check("reset busy",  int'(bus.busy),  0);
      rst = 1'b0;
      @(negedge clk);

      // 1234 with 8-cycle dwells: latency and busy width.
      v0 = valid_cnt; b0 = busy_cnt; e0 = err_cnt;
      send_frame(1234, 8, 0);
      wait_valid(v0, "t1234", 1234);
      check("t1234 valid latency", valid_cyc - last_n, 18);
      check("t1234 busy cycles", busy_cnt - b0, 14);
      check("t1234 err", err_cnt - e0, 0);

      // Table of frames (9999 then 0000 first).
      e0 = err_cnt;
      v0 = valid_cnt;
      for (int i = 0; i < 6; i++) begin
         int p;
         p = valid_cnt;
         send_frame(tbl[i].value, tbl[i].dwell, tbl[i].rot);
         wait_valid(p, $sformatf("tbl%0d", i), int'(tbl[i].exp_num));
         if (i == 1) check("two frames valid pulses", valid_cnt - v0, 2);
      end
      check("table err", err_cnt - e0, 0);

      // Glitch: tens held 2 cycles is not captured.
      v0 = valid_cnt;
      show(an_of(0), seg_of(8), 8);
      show(an_of(1), seg_of(7), 2);
      show(an_of(2), seg_of(6), 8);
      show(an_of(3), seg_of(5), 8);
      repeat (20) @(negedge clk);
      check("glitch no valid", valid_cnt - v0, 0);
      show(an_of(1), seg_of(7), 8);
      wait_valid(v0, "glitch", 5678);

      // Blank code: err pulse, seen cleared, then 0042.
      v0 = valid_cnt; e0 = err_cnt;
      show(an_of(0), seg_of(2), 6);
      show(an_of(2), seg_of(0), 6);
      show(an_of(3), seg_of(0), 6);
      show(an_of(1), 7'b1111111, 6);
      check("blank err pulses", err_cnt - e0, 1);
      check("blank err timing", err_cyc - last_n, 4);
      show(an_of(1), seg_of(4), 6);
      repeat (20) @(negedge clk);
      check("blank seen cleared", valid_cnt - v0, 0);
      show(an_of(0), seg_of(2), 6);
      show(an_of(2), seg_of(0), 6);
      show(an_of(3), seg_of(0), 6);
      wait_valid(v0, "after blank", 42);

      // Invalid anode patterns neither capture nor disturb seen.
      v0 = valid_cnt; e0 = err_cnt;
      show(an_of(0), seg_of(1), 6);
      show(an_of(1), seg_of(2), 6);
      show(an_of(2), seg_of(3), 6);
      show(4'b1100, seg_of(9), 20);
      show(4'b1111, seg_of(9), 20);
      check("bad anode valid", valid_cnt - v0, 0);
      check("bad anode err", err_cnt - e0, 0);
      show(an_of(3), seg_of(4), 6);
      wait_valid(v0, "bad anode", 4321);

      // Reset in the middle of conversion.
      v0 = valid_cnt;
      send_frame(4321, 5, 0);
      while (cyc < last_n + 9) @(negedge clk);
      check("midconv busy", int'(bus.busy), 1);
      rst = 1'b1;
      @(negedge clk);
      check("rst num",   int'(bus.num),   0);
      check("rst busy",  int'(bus.busy),  0);
      check("rst valid", int'(bus.valid), 0);
      check("rst err",   int'(bus.err),   0);
      rst = 1'b0;
      repeat (20) @(negedge clk);
      check("rst no valid", valid_cnt - v0, 0);
      send_frame(4321, 6, 2);
      wait_valid(v0, "after rst", 4321);

      // Random frames against an arithmetic model.
      for (int i = 0; i < 15; i++) begin
         int p;
         for (int k = 0; k < 4; k++) d[k] = int'($urandom_range(0, 9));
         v = d[0] + 10 * d[1] + 100 * d[2] + 1000 * d[3];
         p = valid_cnt;
         send_frame(v, int'($urandom_range(4, 10)), int'($urandom_range(0, 3)));
         wait_valid(p, $sformatf("rand%0d", i), v);
      end

      check("valid_err_overlap", both_cnt, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
